// File: rtl/memory_stage.sv
// MEM pipeline stage: drives a handshaked data-memory port, stalls upstream
// while a load/store is outstanding, and fills the MEM/WB register.
module memory_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        branch,
    input  logic        jump,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [31:0] add_out1,
    input  logic [31:0] alu_out,
    input  logic        aluzero_out,
    input  logic [31:0] readdata2_out,
    input  logic [4:0]  muxRegDst_out,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        jump_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic        wb_MemtoReg,
    output logic [31:0] wb_readdata,
    output logic [31:0] wb_alu,
    output logic [4:0]  wb_rd,
    output logic        mem_fault
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [4:0]  lat_rd_q, lat_rd_d;
    logic        lat_regwrite_q, lat_regwrite_d;
    logic        lat_memtoreg_q, lat_memtoreg_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        wb_memtoreg_q, wb_memtoreg_d;
    logic [31:0] wb_readdata_q, wb_readdata_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        mem_fault_q, mem_fault_d;

    logic mem_op;
    logic aligned;
    logic issue_ok;
    logic illegal;

    // Decode of the EX/MEM slot
    always_comb begin
        mem_op   = in_valid & (MemRead ^ MemWrite);
        aligned  = (alu_out[1:0] == 2'b00);
        issue_ok = mem_op & aligned;
        illegal  = in_valid & ((MemRead & MemWrite) | (mem_op & ~aligned));
    end

    // Combinational control-flow outputs and upstream stall
    always_comb begin
        stall      = ((state_q == IDLE) & issue_ok) | ((state_q == BUSY) & ~dmem_ack);
        pc_src     = in_valid & branch & aluzero_out;
        pc_target  = add_out1;
        jump_taken = in_valid & jump;
    end

    // Next-state and MEM/WB update; an issuing memory op writes a bubble so the
    // previous WB entry is not retired twice while the access is outstanding
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        lat_rd_d       = lat_rd_q;
        lat_regwrite_d = lat_regwrite_q;
        lat_memtoreg_d = lat_memtoreg_q;
        wb_valid_d     = wb_valid_q;
        wb_regwrite_d  = wb_regwrite_q;
        wb_memtoreg_d  = wb_memtoreg_q;
        wb_readdata_d  = wb_readdata_q;
        wb_alu_d       = wb_alu_q;
        wb_rd_d        = wb_rd_q;
        mem_fault_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (issue_ok) begin
                    state_d        = BUSY;
                    cnt_d          = '0;
                    dmem_req_d     = 1'b1;
                    dmem_we_d      = MemWrite;
                    dmem_addr_d    = alu_out;
                    dmem_wdata_d   = readdata2_out;
                    lat_rd_d       = muxRegDst_out;
                    lat_regwrite_d = RegWrite;
                    lat_memtoreg_d = MemtoReg;
                    wb_valid_d     = 1'b0;
                    wb_regwrite_d  = 1'b0;
                end else if (illegal) begin
                    mem_fault_d    = 1'b1;
                    wb_valid_d     = 1'b0;
                    wb_regwrite_d  = 1'b0;
                end else if (in_valid) begin
                    wb_valid_d     = 1'b1;
                    wb_alu_d       = alu_out;
                    wb_rd_d        = muxRegDst_out;
                    wb_regwrite_d  = RegWrite;
                    wb_memtoreg_d  = MemtoReg;
                end else begin
                    wb_valid_d     = 1'b0;
                    wb_regwrite_d  = 1'b0;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d       = IDLE;
                    dmem_req_d    = 1'b0;
                    dmem_we_d     = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_alu_d      = dmem_addr_q;
                    wb_rd_d       = lat_rd_q;
                    wb_regwrite_d = lat_regwrite_q;
                    wb_memtoreg_d = lat_memtoreg_q;
                    if (!dmem_we_q) begin
                        wb_readdata_d = dmem_rdata;
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    dmem_req_d    = 1'b0;
                    dmem_we_d     = 1'b0;
                    mem_fault_d   = 1'b1;
                    wb_valid_d    = 1'b0;
                    wb_regwrite_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register bank with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            lat_rd_q       <= '0;
            lat_regwrite_q <= 1'b0;
            lat_memtoreg_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_readdata_q  <= '0;
            wb_alu_q       <= '0;
            wb_rd_q        <= '0;
            mem_fault_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            lat_rd_q       <= lat_rd_d;
            lat_regwrite_q <= lat_regwrite_d;
            lat_memtoreg_q <= lat_memtoreg_d;
            wb_valid_q     <= wb_valid_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_memtoreg_q  <= wb_memtoreg_d;
            wb_readdata_q  <= wb_readdata_d;
            wb_alu_q       <= wb_alu_d;
            wb_rd_q        <= wb_rd_d;
            mem_fault_q    <= mem_fault_d;
        end
    end

    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_RegWrite = wb_regwrite_q;
    assign wb_MemtoReg = wb_memtoreg_q;
    assign wb_readdata = wb_readdata_q;
    assign wb_alu      = wb_alu_q;
    assign wb_rd       = wb_rd_q;
    assign mem_fault   = mem_fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage (TIMEOUT=4): load, store, faults, timeout,
// branch/jump decode, reset during an outstanding access, ack ignored in IDLE.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, branch, jump, MemRead, MemWrite, RegWrite, MemtoReg;
    logic [31:0] add_out1, alu_out, readdata2_out;
    logic        aluzero_out;
    logic [4:0]  muxRegDst_out;
    logic        stall, pc_src, jump_taken;
    logic [31:0] pc_target;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_RegWrite, wb_MemtoReg, mem_fault;
    logic [31:0] wb_readdata, wb_alu;
    logic [4:0]  wb_rd;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    memory_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .branch(branch),
        .jump(jump), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .add_out1(add_out1), .alu_out(alu_out),
        .aluzero_out(aluzero_out), .readdata2_out(readdata2_out),
        .muxRegDst_out(muxRegDst_out), .stall(stall), .pc_src(pc_src),
        .pc_target(pc_target), .jump_taken(jump_taken), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
        .wb_readdata(wb_readdata), .wb_alu(wb_alu), .wb_rd(wb_rd),
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 0; branch = 0; jump = 0; MemRead = 0; MemWrite = 0;
        RegWrite = 0; MemtoReg = 0; aluzero_out = 0; dmem_ack = 0;
        add_out1 = '0; alu_out = '0; readdata2_out = '0; muxRegDst_out = '0;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic rw,
                         input logic m2r, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r);
        in_valid = v; MemRead = rd; MemWrite = wr; RegWrite = rw; MemtoReg = m2r;
        alu_out = a; readdata2_out = d; muxRegDst_out = r;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        dmem_rdata = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check_val("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_val("rst_dmem_req", 32'(dmem_req), 32'd0);
        check_val("rst_dmem_addr", dmem_addr, 32'd0);
        check_val("rst_wb_alu", wb_alu, 32'd0);
        check_val("rst_mem_fault", 32'(mem_fault), 32'd0);
        #4 reset_n = 1'b1;

        // Load at 0x40, ack on the third BUSY cycle
        tick();
        drive(1, 1, 0, 1, 1, 32'h40, 32'h0, 5'd9);
        #1 check_val("ld_stall_c0", 32'(stall), 32'd1);
        check_val("ld_req_c0", 32'(dmem_req), 32'd0);
        tick();
        check_val("ld_req_c1", 32'(dmem_req), 32'd1);
        check_val("ld_addr", dmem_addr, 32'h40);
        check_val("ld_we", 32'(dmem_we), 32'd0);
        check_val("ld_stall_c1", 32'(stall), 32'd1);
        tick();
        check_val("ld_stall_c2", 32'(stall), 32'd1);
        tick();
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
        #1 check_val("ld_stall_ack", 32'(stall), 32'd0);
        tick();
        idle_inputs();
        dmem_rdata = 32'h0BADF00D;
        check_val("ld_wb_valid", 32'(wb_valid), 32'd1);
        check_val("ld_wb_rdata", wb_readdata, 32'hDEADBEEF);
        check_val("ld_wb_rd", 32'(wb_rd), 32'd9);
        check_val("ld_wb_regwrite", 32'(wb_RegWrite), 32'd1);
        check_val("ld_wb_memtoreg", 32'(wb_MemtoReg), 32'd1);
        check_val("ld_req_done", 32'(dmem_req), 32'd0);

        // Store at 0x44, ack in the cycle the request rises
        drive(1, 0, 1, 0, 0, 32'h44, 32'h12345678, 5'd0);
        #1 check_val("st_stall_c0", 32'(stall), 32'd1);
        tick();
        check_val("st_req", 32'(dmem_req), 32'd1);
        check_val("st_we", 32'(dmem_we), 32'd1);
        check_val("st_addr", dmem_addr, 32'h44);
        check_val("st_wdata", dmem_wdata, 32'h12345678);
        dmem_ack = 1;
        #1 check_val("st_stall_ack", 32'(stall), 32'd0);
        tick();
        idle_inputs();
        check_val("st_we_done", 32'(dmem_we), 32'd0);
        check_val("st_req_done", 32'(dmem_req), 32'd0);
        check_val("st_wb_valid", 32'(wb_valid), 32'd1);
        check_val("st_wb_rdata_hold", wb_readdata, 32'hDEADBEEF);
        check_val("st_wb_alu", wb_alu, 32'h44);

        // Plain ALU op
        drive(1, 0, 0, 1, 0, 32'h55, 32'h0, 5'd3);
        #1 check_val("alu_stall", 32'(stall), 32'd0);
        tick();
        check_val("alu_wb_valid", 32'(wb_valid), 32'd1);
        check_val("alu_wb_alu", wb_alu, 32'h55);
        check_val("alu_wb_rd", 32'(wb_rd), 32'd3);

        // Misaligned load
        drive(1, 1, 0, 1, 1, 32'h42, 32'h0, 5'd6);
        #1 check_val("mis_stall", 32'(stall), 32'd0);
        tick();
        idle_inputs();
        check_val("mis_req", 32'(dmem_req), 32'd0);
        check_val("mis_fault", 32'(mem_fault), 32'd1);
        check_val("mis_wb_valid", 32'(wb_valid), 32'd0);
        check_val("mis_wb_regwrite", 32'(wb_RegWrite), 32'd0);
        tick();
        check_val("mis_fault_end", 32'(mem_fault), 32'd0);

        // Read and write both set
        drive(1, 1, 1, 1, 0, 32'h48, 32'h0, 5'd6);
        #1 check_val("ill_stall", 32'(stall), 32'd0);
        tick();
        idle_inputs();
        check_val("ill_req", 32'(dmem_req), 32'd0);
        check_val("ill_fault", 32'(mem_fault), 32'd1);
        check_val("ill_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        check_val("ill_fault_end", 32'(mem_fault), 32'd0);

        // Timeout: no ack, request held for 4 cycles
        drive(1, 1, 0, 1, 0, 32'h80, 32'h0, 5'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_val("to_req_high", 32'(dmem_req), 32'd1);
            check_val("to_no_fault", 32'(mem_fault), 32'd0);
            tick();
        end
        idle_inputs();
        check_val("to_req_drop", 32'(dmem_req), 32'd0);
        check_val("to_fault", 32'(mem_fault), 32'd1);
        check_val("to_wb_valid", 32'(wb_valid), 32'd0);
        check_val("to_wb_regwrite", 32'(wb_RegWrite), 32'd0);
        tick();
        check_val("to_fault_end", 32'(mem_fault), 32'd0);
        check_val("to_idle_stall", 32'(stall), 32'd0);

        // Branch / jump decode
        in_valid = 1; branch = 1; aluzero_out = 1; add_out1 = 32'h100;
        #1 check_val("br_pc_src", 32'(pc_src), 32'd1);
        check_val("br_target", pc_target, 32'h100);
        check_val("br_stall", 32'(stall), 32'd0);
        aluzero_out = 0;
        #1 check_val("br_nz_pc_src", 32'(pc_src), 32'd0);
        branch = 0; jump = 1;
        #1 check_val("jmp_taken", 32'(jump_taken), 32'd1);
        in_valid = 0;
        #1 check_val("jmp_invalid", 32'(jump_taken), 32'd0);
        tick();
        idle_inputs();

        // Ack while IDLE has no effect
        dmem_ack = 1; dmem_rdata = 32'hCAFEBABE;
        tick();
        dmem_ack = 0;
        check_val("idle_ack_req", 32'(dmem_req), 32'd0);
        check_val("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
        check_val("idle_ack_rdata", wb_readdata, 32'hDEADBEEF);

        // Reset in BUSY, then an ALU op on the first edge after release
        drive(1, 1, 0, 1, 0, 32'h60, 32'h0, 5'd7);
        tick();
        check_val("rb_req", 32'(dmem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_val("rb_req_drop", 32'(dmem_req), 32'd0);
        check_val("rb_wb_valid", 32'(wb_valid), 32'd0);
        check_val("rb_wb_alu", wb_alu, 32'd0);
        check_val("rb_wb_rdata", wb_readdata, 32'd0);
        check_val("rb_wb_rd", 32'(wb_rd), 32'd0);
        drive(1, 0, 0, 1, 0, 32'h7, 32'h0, 5'd2);
        #1 reset_n = 1'b1;
        tick();
        check_val("rb_post_valid", 32'(wb_valid), 32'd1);
        check_val("rb_post_alu", wb_alu, 32'h7);
        check_val("rb_post_req", 32'(dmem_req), 32'd0);
        check_val("rb_post_fault", 32'(mem_fault), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
